flow_vote_packer: RTL and testbench

FLOW_VOTE_PACKER -- requirements
Module: flow_vote_packer

---
 rtl/flow_vote_packer.sv | 229 ++++++++++++++++++++++
 tb/tb_flow_vote_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_vote_packer.sv
// Per-flow entropy voter: packs one verdict bit per flow into WORD_W-bit words, then drains them.
// Define FLOW_VOTE_SCORE_EN to expose the per-flow high-entropy count on o_score/o_score_valid.
module flow_vote_packer #(
    parameter int ENT_W   = 16,
    parameter int PKT_N   = 5,
    parameter int MARK_HI = 7,
    parameter int VOTE_TH = 3,
    parameter int WORD_W  = 64,
    parameter int DEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ENT_W-1:0]  i_pkt_entropy,
    input  logic              i_pkt_valid,
    input  logic [15:0]       i_flow_total,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_done,
    output logic              o_overflow,
    output logic [3:0]        o_score,
    output logic              o_score_valid
);

    localparam int BP_W = $clog2(WORD_W);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [BP_W-1:0] BIT_ZERO = BP_W'(0);
    localparam logic [BP_W-1:0] BIT_ONE  = BP_W'(1);
    localparam logic [BP_W-1:0] BIT_LAST = BP_W'(WORD_W - 1);
    localparam logic [AW:0]     PTR_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]     PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     PTR_FULL = (AW + 1)'(DEPTH);
    localparam logic [3:0]      PKT_LAST = 4'(PKT_N - 1);
    localparam logic [3:0]      MARK_C   = 4'(MARK_HI);
    localparam logic [4:0]      VOTE_C   = 5'(VOTE_TH);

    logic [1:0]        state_r;
    logic [3:0]        pkt_cnt_r;
    logic [3:0]        vote_cnt_r;
    logic [15:0]       flow_cnt_r;
    logic [BP_W-1:0]   bit_ptr_r;
    logic [WORD_W-1:0] word_buf_r;
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              pend_r;
    logic              verdict_r;
    logic              overflow_r;
    logic              done_r;
    logic              rd_valid_r;
    logic [WORD_W-1:0] rd_data_r;
    logic [WORD_W-1:0] mem_r [DEPTH];

    logic              hi_s;
    logic              goto_flush_s;
    logic              pkt_take_s;
    logic              last_pkt_s;
    logic [3:0]        vote_inc_s;
    logic              verdict_s;
    logic [15:0]       flow_next_s;
    logic              wrap_s;
    logic              flush_store_s;
    logic              store_req_s;
    logic              store_en_s;
    logic [WORD_W-1:0] word_with_bit_s;
    logic [WORD_W-1:0] store_data_s;
    logic              unused_entropy_s;

    assign unused_entropy_s = ^i_pkt_entropy;

    // Packet classification, flow-completion detection and word-store decisions.
    always_comb begin
        hi_s            = (i_pkt_entropy[ENT_W-1 -: 4] >= MARK_C);
        flow_next_s     = flow_cnt_r + 16'd1;
        // A pending verdict write counts toward the total in the cycle it lands.
        goto_flush_s    = (state_r == ST_COLLECT) && (i_flow_total != 16'd0) &&
                          (pend_r ? (flow_next_s == i_flow_total) : (flow_cnt_r == i_flow_total));
        pkt_take_s      = (state_r == ST_COLLECT) && i_pkt_valid && !goto_flush_s;
        last_pkt_s      = pkt_take_s && (pkt_cnt_r == PKT_LAST);
        vote_inc_s      = vote_cnt_r + {3'b000, hi_s};
        verdict_s       = ({1'b0, vote_inc_s} > VOTE_C);
        word_with_bit_s = word_buf_r;
        word_with_bit_s[bit_ptr_r] = verdict_r;
        wrap_s          = pend_r && (bit_ptr_r == BIT_LAST);
        flush_store_s   = (state_r == ST_FLUSH) && (bit_ptr_r != BIT_ZERO);
        store_req_s     = wrap_s || flush_store_s;
        store_en_s      = store_req_s && (wr_ptr_r != PTR_FULL);
        store_data_s    = wrap_s ? word_with_bit_s : word_buf_r;
    end

    // Result word storage; contents are only meaningful below wr_ptr.
    always_ff @(posedge i_clk) begin
        if (store_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= store_data_s;
        end
    end

    // Control FSM, counters, verdict packing and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_COLLECT;
            pkt_cnt_r  <= 4'd0;
            vote_cnt_r <= 4'd0;
            flow_cnt_r <= 16'd0;
            bit_ptr_r  <= BIT_ZERO;
            word_buf_r <= {WORD_W{1'b0}};
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            pend_r     <= 1'b0;
            verdict_r  <= 1'b0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WORD_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            pend_r <= last_pkt_s;
            if (last_pkt_s) begin
                verdict_r <= verdict_s;
            end

            if (pkt_take_s) begin
                if (last_pkt_s) begin
                    pkt_cnt_r  <= 4'd0;
                    vote_cnt_r <= 4'd0;
                end else begin
                    pkt_cnt_r  <= pkt_cnt_r + 4'd1;
                    vote_cnt_r <= vote_inc_s;
                end
            end

            if (pend_r) begin
                flow_cnt_r <= flow_next_s;
                if (wrap_s) begin
                    bit_ptr_r  <= BIT_ZERO;
                    word_buf_r <= {WORD_W{1'b0}};
                end else begin
                    bit_ptr_r  <= bit_ptr_r + BIT_ONE;
                    word_buf_r <= word_with_bit_s;
                end
            end

            if (store_req_s) begin
                if (store_en_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end else begin
                    overflow_r <= 1'b1;
                end
            end

            case (state_r)
                ST_COLLECT: begin
                    if (goto_flush_s) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    bit_ptr_r  <= BIT_ZERO;
                    word_buf_r <= {WORD_W{1'b0}};
                    state_r    <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // One-entry output register: refill only once the previous word has left.
                    if (rd_valid_r) begin
                        if (i_rd_ready) begin
                            rd_valid_r <= 1'b0;
                        end
                    end else if (rd_ptr_r != wr_ptr_r) begin
                        rd_data_r  <= mem_r[rd_ptr_r[AW-1:0]];
                        rd_valid_r <= 1'b1;
                        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    pkt_cnt_r  <= 4'd0;
                    vote_cnt_r <= 4'd0;
                    flow_cnt_r <= 16'd0;
                    bit_ptr_r  <= BIT_ZERO;
                    word_buf_r <= {WORD_W{1'b0}};
                    wr_ptr_r   <= PTR_ZERO;
                    rd_ptr_r   <= PTR_ZERO;
                    overflow_r <= 1'b0;
                    state_r    <= ST_COLLECT;
                end
                default: begin
                    state_r <= ST_COLLECT;
                end
            endcase
        end
    end

    assign o_rd_data  = rd_data_r;
    assign o_rd_valid = rd_valid_r;
    assign o_done     = done_r;
    assign o_overflow = overflow_r;

`ifdef FLOW_VOTE_SCORE_EN
    logic [3:0] score_r;
    logic       score_valid_r;

    // Debug score: final vote count, valid in the cycle its verdict bit is written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            score_r       <= 4'd0;
            score_valid_r <= 1'b0;
        end else begin
            score_valid_r <= last_pkt_s;
            if (last_pkt_s) begin
                score_r <= vote_inc_s;
            end
        end
    end

    assign o_score       = score_r;
    assign o_score_valid = score_valid_r;
`else
    assign o_score       = 4'd0;
    assign o_score_valid = 1'b0;
`endif

endmodule

// File: tb/tb_flow_vote_packer.sv
// Scoreboard bench for flow_vote_packer at default parameters: stimulus queues expected
// words/scores, a negedge monitor pops and compares on every transfer.
module tb_flow_vote_packer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_pkt_entropy;
    logic        i_pkt_valid;
    logic [15:0] i_flow_total;
    logic [63:0] o_rd_data;
    logic        o_rd_valid;
    logic        i_rd_ready;
    logic        o_done;
    logic        o_overflow;
    logic [3:0]  o_score;
    logic        o_score_valid;

    flow_vote_packer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pkt_entropy (i_pkt_entropy),
        .i_pkt_valid   (i_pkt_valid),
        .i_flow_total  (i_flow_total),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_score       (o_score),
        .o_score_valid (o_score_valid)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];
    logic [3:0]  score_q [$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev_data  = 64'd0;
    logic        score_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each accepted word and score against the queues, and stall stability.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", {63'd0, o_rd_valid}, 64'd1);
                    check("stall_data", o_rd_data, prev_data);
                end
                if (o_rd_valid && i_rd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h expected none", o_rd_data);
                    end else begin
                        check("rd_word", o_rd_data, exp_q.pop_front());
                    end
                end
                stall_prev = o_rd_valid && !i_rd_ready;
                prev_data  = o_rd_data;
`ifdef FLOW_VOTE_SCORE_EN
                if (o_score_valid) begin
                    if (score_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_score: got %0d expected none", o_score);
                    end else begin
                        check("score", {60'd0, o_score}, {60'd0, score_q.pop_front()});
                    end
                end
`else
                if (o_score_valid || (o_score != 4'd0)) begin
                    score_seen = 1'b1;
                end
`endif
            end
        end
    end

    task automatic send_pkt(input logic [3:0] nib);
        i_pkt_entropy = {nib, 12'h000};
        i_pkt_valid   = 1'b1;
        @(posedge i_clk);
        #1;
        i_pkt_valid   = 1'b0;
        i_pkt_entropy = 16'h0000;
    endtask

    task automatic send_flow5(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2,
                              input logic [3:0] n3, input logic [3:0] n4, input logic [3:0] exp_score);
        score_q.push_back(exp_score);
        send_pkt(n0);
        send_pkt(n1);
        send_pkt(n2);
        send_pkt(n3);
        send_pkt(n4);
    endtask

    // Flagged flow: 5 high packets; unflagged flow: 3 high packets (not above the threshold).
    task automatic send_flag(input logic flag);
        if (flag) begin
            send_flow5(4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd5);
        end else begin
            send_flow5(4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd3);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        logic hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if (o_rd_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check({name, "_rd_valid_seen"}, {63'd0, hit}, 64'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        logic hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                hit = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {63'd0, hit}, 64'd1);
        if (hit) begin
            @(negedge i_clk);
            check({name, "_done_pulse"}, {63'd0, o_done}, 64'd0);
            check({name, "_ovf_cleared"}, {63'd0, o_overflow}, 64'd0);
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic idle_activity;
        i_rst         = 1'b1;
        i_pkt_entropy = 16'h0000;
        i_pkt_valid   = 1'b0;
        i_flow_total  = 16'd0;
        i_rd_ready    = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_rd_valid", {63'd0, o_rd_valid}, 64'd0);
        check("rst_rd_data", o_rd_data, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_overflow", {63'd0, o_overflow}, 64'd0);
        check("rst_score", {59'd0, o_score_valid, o_score}, 64'd0);
        i_rst = 1'b0;

        // Total of zero keeps collecting; raising it to 1 afterwards flushes the one flow.
        send_flag(1'b1);
        idle_activity = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            idle_activity = idle_activity | o_rd_valid | o_done;
        end
        check("total0_holds", {63'd0, idle_activity}, 64'd0);
        exp_q.push_back(64'h1);
        @(posedge i_clk);
        #1;
        i_flow_total = 16'd1;
        wait_done("total0_then1", 100);

        exp_q.push_back(64'h1);
        send_flow5(4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd4);
        wait_done("single_flagged", 100);

        exp_q.push_back(64'h0);
        send_flow5(4'd8, 4'd7, 4'd7, 4'd3, 4'd0, 4'd3);
        wait_done("single_count3", 100);

        // Exactly one full word: stored on wrap, no extra padded word.
        i_flow_total = 16'd64;
        exp_q.push_back(64'h5555_5555_5555_5555);
        for (int i = 0; i < 64; i++) begin
            send_flag((i % 2) == 0);
        end
        wait_done("alt64", 200);

        // Partial word padding plus a 10-cycle read stall.
        i_rd_ready   = 1'b0;
        i_flow_total = 16'd70;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'h0000_0000_0000_003F);
        for (int i = 0; i < 70; i++) begin
            send_flag(1'b1);
        end
        wait_valid("flush70", 200);
        repeat (10) @(posedge i_clk);
        #1;
        i_rd_ready = 1'b1;
        wait_done("flush70", 200);

        // Five words into four slots: last one dropped, overflow visible while draining.
        i_flow_total = 16'd320;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        end
        for (int i = 0; i < 320; i++) begin
            send_flag(1'b1);
        end
        wait_valid("ovf320", 200);
        check("ovf320_overflow_in_drain", {63'd0, o_overflow}, 64'd1);
        wait_done("ovf320", 200);

        // Reset while a word is waiting; a fresh one-flow run must follow cleanly.
        i_rd_ready   = 1'b0;
        i_flow_total = 16'd70;
        for (int i = 0; i < 70; i++) begin
            send_flag(1'b1);
        end
        wait_valid("mid_drain", 200);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid_drain_rst_valid", {63'd0, o_rd_valid}, 64'd0);
        check("mid_drain_rst_data", o_rd_data, 64'd0);
        i_rst        = 1'b0;
        i_flow_total = 16'd1;
        i_rd_ready   = 1'b1;
        exp_q.push_back(64'h1);
        send_flag(1'b1);
        wait_done("after_rst", 100);

`ifdef FLOW_VOTE_SCORE_EN
        check("score_queue_empty", 64'(score_q.size()), 64'd0);
`else
        check("score_tied_low", {63'd0, score_seen}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
